// File: rtl/addr_reg_bank.sv
// Parametrised address register bank (PC / SP / general address registers) with
// per-register load, arithmetic and byte-lane ops, PC auto-increment and bounded-stack checking.
module addr_reg_bank #(
  parameter int unsigned       WIDTH      = 16,
  parameter int unsigned       NREGS      = 4,
  parameter int unsigned       PC_IDX     = 0,
  parameter int unsigned       SP_IDX     = 3,
  parameter logic [WIDTH-1:0]  RESET_PC   = '0,
  parameter logic [WIDTH-1:0]  STACK_BASE = 'h0100,
  parameter logic [WIDTH-1:0]  STACK_TOP  = 'h01FF,
  localparam int unsigned      SELW       = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [NREGS-1:0] RegSel,
  input  logic [2:0]       FunSel,
  input  logic             PCInc,
  input  logic             ErrClr,
  input  logic [SELW-1:0]  OutCSel,
  input  logic [SELW-1:0]  OutDSel,
  output logic [WIDTH-1:0] OutC,
  output logic [WIDTH-1:0] OutD,
  output logic             StackOvf,
  output logic             StackUnf
);

  localparam logic [2:0] FN_HOLD = 3'b000;
  localparam logic [2:0] FN_CLR  = 3'b001;
  localparam logic [2:0] FN_LOAD = 3'b010;
  localparam logic [2:0] FN_INC  = 3'b011;
  localparam logic [2:0] FN_DEC  = 3'b100;
  localparam logic [2:0] FN_ADD  = 3'b101;
  localparam logic [2:0] FN_LBZ  = 3'b110;
  localparam logic [2:0] FN_LBK  = 3'b111;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] regs     [NREGS];
  logic [WIDTH-1:0] regs_nxt [NREGS];

  logic                    sp_chk;
  logic                    sp_ovf;
  logic                    sp_unf;
  logic signed [WIDTH+1:0] sp_res;
  logic signed [WIDTH+1:0] sp_cur;
  logic signed [WIDTH+1:0] top_x;
  logic signed [WIDTH+1:0] base_x;

  // SP result is evaluated two bits wider and signed so that both wrap
  // directions compare correctly against the stack bounds.
  always_comb begin
    sp_cur = $signed({2'b00, regs[SP_IDX]});
    top_x  = $signed({2'b00, STACK_TOP});
    base_x = $signed({2'b00, STACK_BASE});
    sp_res = sp_cur;
    sp_chk = 1'b0;
    case (FunSel)
      FN_INC: begin
        sp_res = sp_cur + $signed((WIDTH+2)'(1));
        sp_chk = RegSel[SP_IDX];
      end
      FN_DEC: begin
        sp_res = sp_cur - $signed((WIDTH+2)'(1));
        sp_chk = RegSel[SP_IDX];
      end
      FN_ADD: begin
        sp_res = sp_cur + $signed({2'b00, I});
        sp_chk = RegSel[SP_IDX];
      end
      default: begin
        sp_res = sp_cur;
        sp_chk = 1'b0;
      end
    endcase
    sp_ovf = sp_chk && (sp_res > top_x);
    sp_unf = sp_chk && (sp_res < base_x);
  end

  always_comb begin
    for (int unsigned k = 0; k < NREGS; k++) begin
      regs_nxt[k] = regs[k];
      if (RegSel[k]) begin
        case (FunSel)
          FN_HOLD: regs_nxt[k] = regs[k];
          FN_CLR:  regs_nxt[k] = '0;
          FN_LOAD: regs_nxt[k] = I;
          FN_INC:  regs_nxt[k] = regs[k] + ONE;
          FN_DEC:  regs_nxt[k] = regs[k] - ONE;
          FN_ADD:  regs_nxt[k] = regs[k] + I;
          FN_LBZ:  regs_nxt[k] = {{(WIDTH-8){1'b0}}, I[7:0]};
          FN_LBK:  regs_nxt[k] = {regs[k][WIDTH-1:8], I[7:0]};
          default: regs_nxt[k] = regs[k];
        endcase
      end
    end
    if (sp_ovf || sp_unf) begin
      regs_nxt[SP_IDX] = regs[SP_IDX];
    end
    // An explicit PC op takes precedence over auto-increment.
    if (PCInc && !RegSel[PC_IDX]) begin
      regs_nxt[PC_IDX] = regs[PC_IDX] + ONE;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        if (k == PC_IDX) begin
          regs[k] <= RESET_PC;
        end else if (k == SP_IDX) begin
          regs[k] <= STACK_TOP;
        end else begin
          regs[k] <= '0;
        end
      end
      StackOvf <= 1'b0;
      StackUnf <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NREGS; k++) begin
        regs[k] <= regs_nxt[k];
      end
      StackOvf <= (StackOvf && !ErrClr) || sp_ovf;
      StackUnf <= (StackUnf && !ErrClr) || sp_unf;
    end
  end

  // Unmatched selects (>= NREGS) fall through to zero.
  always_comb begin
    OutC = '0;
    OutD = '0;
    for (int unsigned k = 0; k < NREGS; k++) begin
      if (OutCSel == SELW'(k)) OutC = regs[k];
      if (OutDSel == SELW'(k)) OutD = regs[k];
    end
  end

endmodule

// File: tb/tb_addr_reg_bank.sv
// Directed self-checking bench for addr_reg_bank with default parameters
// (PC=reg0, AR=reg1, reg2 general, SP=reg3).
module tb_addr_reg_bank;

  logic        Clock;
  logic        Reset;
  logic [15:0] I;
  logic [3:0]  RegSel;
  logic [2:0]  FunSel;
  logic        PCInc;
  logic        ErrClr;
  logic [1:0]  OutCSel;
  logic [1:0]  OutDSel;
  logic [15:0] OutC;
  logic [15:0] OutD;
  logic        StackOvf;
  logic        StackUnf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  addr_reg_bank #(
    .WIDTH(16),
    .NREGS(4),
    .PC_IDX(0),
    .SP_IDX(3),
    .RESET_PC(16'h0000),
    .STACK_BASE(16'h0100),
    .STACK_TOP(16'h01FF)
  ) dut (
    .Clock(Clock),
    .Reset(Reset),
    .I(I),
    .RegSel(RegSel),
    .FunSel(FunSel),
    .PCInc(PCInc),
    .ErrClr(ErrClr),
    .OutCSel(OutCSel),
    .OutDSel(OutDSel),
    .OutC(OutC),
    .OutD(OutD),
    .StackOvf(StackOvf),
    .StackUnf(StackUnf)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] rs, input logic [2:0] fs, input logic [15:0] d,
                     input logic pci, input logic clr);
    @(negedge Clock);
    RegSel = rs; FunSel = fs; I = d; PCInc = pci; ErrClr = clr;
    @(posedge Clock);
    #1;
    RegSel = '0; FunSel = '0; I = '0; PCInc = 1'b0; ErrClr = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] idx, input logic [15:0] exp);
    OutCSel = idx;
    OutDSel = idx;
    #1;
    check_eq({tag, ".C"}, OutC, exp);
    check_eq({tag, ".D"}, OutD, exp);
  endtask

  task automatic flags(input string tag, input logic o, input logic u);
    check_eq({tag, ".ovf"}, {15'b0, StackOvf}, {15'b0, o});
    check_eq({tag, ".unf"}, {15'b0, StackUnf}, {15'b0, u});
  endtask

  initial begin
    Reset = 1'b1; I = '0; RegSel = '0; FunSel = '0; PCInc = 1'b0; ErrClr = 1'b0;
    OutCSel = '0; OutDSel = '0;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;

    rd("rst.pc", 2'd0, 16'h0000);
    rd("rst.ar", 2'd1, 16'h0000);
    rd("rst.r2", 2'd2, 16'h0000);
    rd("rst.sp", 2'd3, 16'h01FF);
    flags("rst", 1'b0, 1'b0);

    cyc(4'b0010, 3'b010, 16'h1234, 1'b0, 1'b0);
    rd("ld.ar", 2'd1, 16'h1234);
    rd("ld.pc", 2'd0, 16'h0000);
    cyc(4'b0010, 3'b011, 16'h0000, 1'b0, 1'b0);
    rd("inc.ar", 2'd1, 16'h1235);
    cyc(4'b0010, 3'b101, 16'h0010, 1'b0, 1'b0);
    rd("add.ar", 2'd1, 16'h1245);

    // No write-through: pending load is not visible before its edge
    @(negedge Clock);
    RegSel = 4'b0010; FunSel = 3'b010; I = 16'h5555;
    rd("nowt.ar", 2'd1, 16'h1245);
    @(posedge Clock);
    #1;
    RegSel = '0; FunSel = '0; I = '0;
    rd("wt.ar", 2'd1, 16'h5555);

    cyc(4'b0010, 3'b010, 16'hFFFF, 1'b0, 1'b0);
    cyc(4'b0010, 3'b011, 16'h0000, 1'b0, 1'b0);
    rd("wrap.inc", 2'd1, 16'h0000);
    cyc(4'b0010, 3'b100, 16'h0000, 1'b0, 1'b0);
    rd("wrap.dec", 2'd1, 16'hFFFF);
    flags("wrap", 1'b0, 1'b0);

    cyc(4'b0110, 3'b010, 16'h0007, 1'b0, 1'b0);
    rd("multi.ar", 2'd1, 16'h0007);
    rd("multi.r2", 2'd2, 16'h0007);
    cyc(4'b0100, 3'b001, 16'h0000, 1'b0, 1'b0);
    rd("clr.r2", 2'd2, 16'h0000);
    rd("clr.ar", 2'd1, 16'h0007);

    repeat (3) cyc(4'b0000, 3'b000, 16'h0000, 1'b1, 1'b0);
    rd("pcinc3", 2'd0, 16'h0003);
    cyc(4'b0001, 3'b010, 16'h0040, 1'b1, 1'b0);
    rd("pc.opwins", 2'd0, 16'h0040);
    cyc(4'b0001, 3'b010, 16'hFFFF, 1'b0, 1'b0);
    cyc(4'b0010, 3'b011, 16'h0000, 1'b1, 1'b0);
    rd("pc.wrap", 2'd0, 16'h0000);
    rd("pc.wrap.ar", 2'd1, 16'h0008);

    cyc(4'b1000, 3'b011, 16'h0000, 1'b0, 1'b0);
    rd("sp.ovf", 2'd3, 16'h01FF);
    flags("sp.ovf", 1'b1, 1'b0);
    cyc(4'b1000, 3'b010, 16'h0100, 1'b0, 1'b0);
    rd("sp.ld", 2'd3, 16'h0100);
    flags("sp.ld", 1'b1, 1'b0);
    cyc(4'b1000, 3'b100, 16'h0000, 1'b0, 1'b0);
    rd("sp.unf", 2'd3, 16'h0100);
    flags("sp.unf", 1'b1, 1'b1);
    cyc(4'b0000, 3'b000, 16'h0000, 1'b0, 1'b1);
    flags("errclr", 1'b0, 1'b0);

    cyc(4'b1000, 3'b101, 16'h0050, 1'b0, 1'b0);
    rd("sp.add", 2'd3, 16'h0150);
    cyc(4'b1000, 3'b100, 16'h0000, 1'b0, 1'b0);
    rd("sp.dec", 2'd3, 16'h014F);
    flags("sp.ok", 1'b0, 1'b0);
    cyc(4'b1000, 3'b101, 16'hFFFF, 1'b0, 1'b0);
    rd("sp.addwrap", 2'd3, 16'h014F);
    flags("sp.addwrap", 1'b1, 1'b0);
    cyc(4'b1000, 3'b010, 16'h01FF, 1'b0, 1'b1);
    flags("sp.ldclr", 1'b0, 1'b0);
    cyc(4'b1000, 3'b011, 16'h0000, 1'b0, 1'b1);
    flags("clr+ovf", 1'b1, 1'b0);
    cyc(4'b1000, 3'b110, 16'h0000, 1'b0, 1'b0);
    rd("sp.ldz", 2'd3, 16'h0000);
    flags("sp.ldz", 1'b1, 1'b0);

    cyc(4'b0010, 3'b010, 16'hABCD, 1'b0, 1'b0);
    cyc(4'b0010, 3'b111, 16'h0012, 1'b0, 1'b0);
    rd("byte.keep", 2'd1, 16'hAB12);
    cyc(4'b0010, 3'b110, 16'hFF12, 1'b0, 1'b0);
    rd("byte.zero", 2'd1, 16'h0012);

    cyc(4'b0001, 3'b010, 16'h0077, 1'b0, 1'b0);
    @(negedge Clock);
    Reset = 1'b1; RegSel = 4'b1111; FunSel = 3'b011; PCInc = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0; RegSel = '0; FunSel = '0; PCInc = 1'b0;
    rd("mrst.pc", 2'd0, 16'h0000);
    rd("mrst.ar", 2'd1, 16'h0000);
    rd("mrst.sp", 2'd3, 16'h01FF);
    flags("mrst", 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
